sram_controller: RTL
====================

# sram_controller

Bridges the MEM stage's single-cycle data-memory request (read/write enable, 32-bit ALU-computed address, 32-bit store data) to an external 256K×16 asynchronous SRAM. Each 32-bit access becomes two 16-bit SRAM transactions plus wait states. The controller holds `ready` low until the access completes, and the processor uses `~ready` to freeze every pipeline stage. The block sits directly downstream of the MEM stage and replaces the on-chip data memory.

## Interface
- `ACCESS_CYCLES`, 6: total cycles per access, counted from request detection to the `ready` cycle inclusive; legal range 4..15.
- `BASE_ADDR`, 1024: processor byte address that maps to SRAM word 0.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  store request from the MEM stage.
- `rd_en`  in  1  load request from the MEM stage.
- `address`  in  32  byte address (the ALU result).
- `wr_data`  in  32  store data (Val_Rm).
- `rd_data`  out  32  load result.
- `ready`  out  1  access complete or no request; the pipeline freezes when this is 0.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM word address.
- `SRAM_WE_N`  out  1  SRAM write enable, active low.
- `SRAM_OE_N`  out  1  SRAM output enable, active low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  tied to 0.

## Operation
Address mapping:
- Effective address `eff = address - BASE_ADDR`, computed mod 2^32; bits [1:0] are ignored.
- Low half-word goes to `SRAM_ADDR = {eff[18:2],1'b0}` and carries data bits [15:0].
- High half-word goes to `{eff[18:2],1'b1}` and carries data bits [31:16].
- Bits [31:19] of `eff` are discarded, so the address space wraps.

The FSM has states IDLE, LOW, HIGH, WAIT and DONE, with a 4-bit cycle counter:
- **IDLE:** if `wr_en|rd_en`, latch `address`, `wr_data` and the operation type, then go to LOW. If both enables are high, the write wins.
- **LOW:** drive the low address.
  - Write: `SRAM_WE_N=0`, `SRAM_OE_N=1`, DQ driven with `wr_data[15:0]`.
  - Read: `SRAM_WE_N=1`, `SRAM_OE_N=0`, DQ high-Z, and `SRAM_DQ` is sampled into `rd_data[15:0]` at the end of the cycle.
  - Next state: HIGH.
- **HIGH:** the same as LOW using the high address and bits [31:16].
  - Next state: WAIT if `ACCESS_CYCLES>4`, otherwise DONE.
- **WAIT:** bus idle (`WE_N=1`, DQ high-Z, `SRAM_ADDR` holds the high address). The controller stays here for `ACCESS_CYCLES-4` cycles, then goes to DONE.
- **DONE:** `ready=1`, `rd_data` is valid, and the next state is IDLE.

`ready` is combinational:
- `ready = (state==IDLE & ~wr_en & ~rd_en) | (state==DONE)`.
- In LOW, HIGH and WAIT, `ready` is 0 regardless of the inputs.

Other rules:
- Latched operands are used throughout the access. Input changes after IDLE are ignored, and an access always runs to completion.
- `rd_data` updates only during read accesses. It keeps its value across writes and idle cycles.
- DQ is driven only in the LOW and HIGH states of a write; at all other times it is high-Z.

## Timing
- A request is detected in cycle 0 (IDLE). `ready` is 0 for cycles 0 through `ACCESS_CYCLES-2` and 1 in cycle `ACCESS_CYCLES-1` (DONE).
- With the defaults, that gives 5 freeze cycles followed by 1 ready cycle.
- Back-to-back accesses: a request present in the cycle after DONE starts a new access immediately, with no dead cycle.
- The SRAM write pulse is exactly one cycle per half-word.
- Read data is sampled at the rising edge that ends LOW or HIGH.
- Reset (`rst=0`), asynchronous and at any time, including mid-access:
  - state goes to IDLE, `rd_data=0`, `SRAM_WE_N=1`, `SRAM_OE_N=0`, `SRAM_ADDR=0`, DQ high-Z, counter 0;
  - `ready` then follows the IDLE equation;
  - an aborted write may leave one half-word written.

## Test plan
- Write `address=1024`, `wr_data=0xDEADBEEF`, then read the same address. Required: SRAM word 0 = 0xBEEF, word 1 = 0xDEAD, read returns 0xDEADBEEF, and `ready` is low for exactly 5 cycles per access.
- Idle with no enables: `ready=1` continuously, `WE_N=1`, DQ high-Z.
- Two back-to-back reads at 1028 and 1032 (preloaded 0x11112222 and 0x33334444). Required: the second access starts in the cycle after the first DONE, and the values arrive in order.
- Assert `rst=0` during HIGH of a write to 1036. Required: an immediate return to IDLE with `WE_N=1`; a subsequent read of 1036 completes normally.
- Assert `wr_en=1` and `rd_en=1` together with `wr_data=0xCAFEF00D` at 1040. Required: a write is performed and `rd_data` is unchanged.
- Set `ACCESS_CYCLES=4` and write to `address=1024+0x80000` (which wraps to SRAM word 0). Required: `ready` is low for 3 cycles and word 0 is written.

Source files
------------

// File: rtl/sram_controller.sv
// Turns a one-cycle 32-bit MEM-stage load/store into two 16-bit async SRAM
// transactions plus wait states; ready stays low until the access completes.
module sram_controller #(
    parameter int          ACCESS_CYCLES = 6,
    parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);
    typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_WAIT, S_DONE} state_e;

    // WAIT lasts ACCESS_CYCLES-4 cycles; counter runs 0..WAIT_LAST
    localparam logic [3:0] WAIT_LAST = 4'(ACCESS_CYCLES > 4 ? ACCESS_CYCLES - 5 : 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] eff;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        unused_eff;

    assign eff        = address - BASE_ADDR;
    assign unused_eff = ^{eff[31:19], eff[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        rd_data_d = rd_data_q;
        ready     = 1'b0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_ADDR = 18'd0;
        dq_oe     = 1'b0;
        dq_out    = 16'd0;
        case (state_q)
            S_IDLE: begin
                SRAM_OE_N = 1'b0;
                ready     = ~wr_en & ~rd_en;
                if (wr_en | rd_en) begin
                    waddr_d = eff[18:2];
                    wdata_d = wr_data;
                    wr_d    = wr_en;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                SRAM_ADDR = {waddr_q, 1'b0};
                SRAM_WE_N = ~wr_q;
                SRAM_OE_N = wr_q;
                dq_oe     = wr_q;
                dq_out    = wdata_q[15:0];
                if (!wr_q) rd_data_d[15:0] = SRAM_DQ;
                state_d   = S_HIGH;
            end
            S_HIGH: begin
                SRAM_ADDR = {waddr_q, 1'b1};
                SRAM_WE_N = ~wr_q;
                SRAM_OE_N = wr_q;
                dq_oe     = wr_q;
                dq_out    = wdata_q[31:16];
                if (!wr_q) rd_data_d[31:16] = SRAM_DQ;
                cnt_d     = 4'd0;
                state_d   = (ACCESS_CYCLES > 4) ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
                SRAM_ADDR = {waddr_q, 1'b1};
                if (cnt_q == WAIT_LAST) state_d = S_DONE;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            S_DONE: begin
                SRAM_ADDR = {waddr_q, 1'b1};
                ready     = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            waddr_q   <= 17'd0;
            wdata_q   <= 32'd0;
            wr_q      <= 1'b0;
            rd_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
endmodule
